// File: rtl/fetch_pkg.sv
// fetch_pkg: widths, FSM encoding and prefetch entry type
// shared by the instruction fetch stage.
package fetch_pkg;
   localparam int RW       = 16;
   localparam int INSTR_W  = 32;
   localparam int FIFO_LOG = 2;
   localparam int DEPTH    = 1 << FIFO_LOG;
   localparam int CW       = FIFO_LOG + 1;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_REQ         = 2'd1,
      S_REQ_DISCARD = 2'd2
   } state_e;

   typedef struct packed {
      logic [RW-1:0]      pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory bus plus execute handshake.
// master = fetch stage, slave = memory/execute side.
interface fetch_if;
   import fetch_pkg::*;

   logic               o_mem_req;
   logic [RW-1:0]      o_mem_addr;
   logic               i_mem_ack;
   logic [INSTR_W-1:0] i_mem_data;
   logic               i_ready;
   logic               o_submit;
   logic [INSTR_W-1:0] o_instr;
   logic [RW-1:0]      o_instr_pc;
   logic [RW-1:0]      i_exec_pc;
   logic               o_flush;

   modport master (
      output o_mem_req, o_mem_addr, o_submit,
      output o_instr, o_instr_pc, o_flush,
      input  i_mem_ack, i_mem_data, i_ready, i_exec_pc
   );

   modport slave (
      input  o_mem_req, o_mem_addr, o_submit,
      input  o_instr, o_instr_pc, o_flush,
      output i_mem_ack, i_mem_data, i_ready, i_exec_pc
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {pc, instr} with clear.
// Head reads as zero while empty.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          clear_i,
   input  entry_t        data_i,
   output entry_t        data_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   entry_t              mem_q [DEPTH];
   logic [FIFO_LOG-1:0] wr_q, rd_q;
   logic [CW-1:0]       cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + FIFO_LOG'(1);
         if (pop_i)  rd_q <= rd_q + FIFO_LOG'(1);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_q] <= data_i;
   end

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: rtl/fetch.sv
// fetch: sequential-PC fetch, one outstanding request, prefetch FIFO.
// Build option FETCH_BYPASS_EN forwards the ack word straight to execute.
module fetch
   import fetch_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   fetch_if.master bus
);
   state_e        state_q;
   logic [RW-1:0] fetch_pc_q, inflight_pc_q, mem_addr_q;
   logic          mem_req_q;

   entry_t        head, push_e;
   logic [CW-1:0] cnt, cnt_nx;
   logic          empty, full, push, pop, clr;
   logic          ack, take, byp, redirect, room, issue;
   logic [RW-1:0] exp_pc, iss_pc;

   always_comb begin
      // stray acks while idle are ignored
      ack = bus.i_mem_ack && (state_q != S_IDLE);
      if (!empty)               exp_pc = head.pc;
      else if (state_q == S_REQ) exp_pc = inflight_pc_q;
      else                      exp_pc = fetch_pc_q;
      redirect = (exp_pc != bus.i_exec_pc);
      take = !empty && bus.i_ready
          && (head.pc == bus.i_exec_pc);
`ifdef FETCH_BYPASS_EN
      byp = empty && !redirect && bus.i_ready && ack
         && (state_q == S_REQ)
         && (inflight_pc_q == bus.i_exec_pc);
`else
      byp = 1'b0;
`endif
      pop          = take;
      clr          = redirect;
      push         = ack && (state_q == S_REQ) && !redirect && !byp;
      push_e.pc    = inflight_pc_q;
      push_e.instr = bus.i_mem_data;
      cnt_nx = cnt + CW'(push) - CW'(pop);
      room   = (cnt_nx < CW'(DEPTH));
      iss_pc = redirect ? bus.i_exec_pc : fetch_pc_q;
      unique case (state_q)
         S_IDLE:        issue = redirect || room;
         S_REQ:         issue = ack && (redirect || room);
         S_REQ_DISCARD: issue = ack;
         default:       issue = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= '0;
         inflight_pc_q <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
      end else if (issue) begin
         state_q       <= S_REQ;
         mem_req_q     <= 1'b1;
         mem_addr_q    <= iss_pc;
         inflight_pc_q <= iss_pc;
         fetch_pc_q    <= iss_pc + RW'(1);
      end else if (redirect) begin
         // request still pending: let it finish, drop its data
         fetch_pc_q <= bus.i_exec_pc;
         state_q    <= S_REQ_DISCARD;
      end else if (ack) begin
         state_q   <= S_IDLE;
         mem_req_q <= 1'b0;
      end
   end

   fetch_fifo u_fifo (
      .clk_i   (i_clk),
      .rst_ni  (i_rst),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (clr),
      .data_i  (push_e),
      .data_o  (head),
      .count_o (cnt),
      .full_o  (full),
      .empty_o (empty)
   );

   a_no_push_full: assert property (
      @(posedge i_clk) disable iff (!i_rst) !(push && full));

   assign bus.o_mem_req  = mem_req_q;
   assign bus.o_mem_addr = mem_addr_q;
   assign bus.o_submit   = take || byp;
   assign bus.o_flush    = redirect;
   assign bus.o_instr    = byp ? bus.i_mem_data : head.instr;
   assign bus.o_instr_pc = byp ? inflight_pc_q : head.pc;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: fetch stage against a memory/execute model
// that expects an in-order instruction stream.
module tb_fetch;
   import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   fetch_if bus();
   fetch dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [RW-1:0] exec_pc;
   logic          ready;
   int            lat;
   logic          jmp, jumped;
   logic [RW-1:0] jmp_tgt;
   logic          m_busy, ack;
   int            m_wait;
   logic [RW-1:0] m_addr;
   logic          s_req, s_sub, s_flush;
   logic [RW-1:0] s_ipc;
   logic [RW-1:0] req_log[$];
   logic [RW-1:0] sub_log[$];
   int            sub_cyc[$];
   int            cyc;
   int            n9;

   function automatic logic [INSTR_W-1:0] word(input logic [RW-1:0] a);
      return {a ^ 16'hA5C3, ~a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      jumped = jmp;
      if (jmp) exec_pc = jmp_tgt;
      jmp = 1'b0;
      bus.i_exec_pc = exec_pc;
      bus.i_ready   = ready;
      if (bus.o_mem_req) begin
         if (!m_busy) begin
            m_busy = 1'b1;
            m_wait = lat;
            m_addr = bus.o_mem_addr;
            req_log.push_back(m_addr);
         end else begin
            chk("addr_hold", 32'(bus.o_mem_addr), 32'(m_addr));
         end
      end
      ack = m_busy && (m_wait == 0);
      bus.i_mem_ack  = ack;
      bus.i_mem_data = ack ? word(m_addr) : $urandom();
      #1;
      s_req   = bus.o_mem_req;
      s_sub   = bus.o_submit;
      s_flush = bus.o_flush;
      s_ipc   = bus.o_instr_pc;
      chk("flush", 32'(s_flush), 32'(jumped));
      if (s_sub) begin
         chk("sub_pc", 32'(s_ipc), 32'(exec_pc));
         chk("sub_instr", bus.o_instr, word(exec_pc));
         chk("sub_ready", 32'(ready), 32'd1);
         sub_log.push_back(s_ipc);
         sub_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (ack) m_busy = 1'b0;
      else if (m_busy) m_wait--;
      if (s_sub) exec_pc++;
      cyc++;
   endtask

   task automatic clear_logs();
      req_log.delete();
      sub_log.delete();
      sub_cyc.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      exec_pc = '0;
      bus.i_exec_pc = '0;
      bus.i_mem_ack = 1'b0;
      bus.i_ready   = 1'b0;
      bus.i_mem_data = '0;
      m_busy = 1'b0;
      jmp = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_logs();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},  32'(bus.o_mem_req), 32'd0);
      chk({tag, "_addr"}, 32'(bus.o_mem_addr), 32'd0);
      chk({tag, "_sub"},  32'(bus.o_submit), 32'd0);
      chk({tag, "_flush"}, 32'(bus.o_flush), 32'd0);
      chk({tag, "_instr"}, bus.o_instr, 32'd0);
      chk({tag, "_ipc"},  32'(bus.o_instr_pc), 32'd0);
   endtask

   initial begin
      exec_pc = '0; ready = 1'b0; lat = 0; cyc = 0;
      jmp = 1'b0; jmp_tgt = '0; jumped = 1'b0;
      m_busy = 1'b0; m_wait = 0; m_addr = '0; ack = 1'b0;
      bus.i_exec_pc = '0; bus.i_ready = 1'b0;
      bus.i_mem_ack = 1'b0; bus.i_mem_data = '0;
      #1 rst = 1'b0;
      #2 chk_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      clear_logs();

      // zero-wait stream
      ready = 1'b1; lat = 0;
      repeat (12) cycle();
      for (int i = 0; i < 4; i++)
         chk("stream_pc", 32'(sub_log[i]), 32'(i));
      chk("stream_consec", 32'(sub_cyc[3] - sub_cyc[0]), 32'd3);
      chk("stream_rate", 32'(sub_log.size() >= 8), 32'd1);

      // execute stalled: FIFO fills then fetch stops
      do_reset();
      ready = 1'b0; lat = 0;
      repeat (10) cycle();
      chk("stall_reqs", 32'(req_log.size()), 32'd4);
      chk("stall_req_low", 32'(s_req), 32'd0);
      ready = 1'b1;
      repeat (8) cycle();
      for (int i = 0; i < 4; i++)
         chk("drain_pc", 32'(sub_log[i]), 32'(i));
      chk("resume_addr", 32'(req_log[4]), 32'd4);

      // redirect with a full FIFO holding 5..8
      do_reset();
      ready = 1'b1; lat = 0;
      for (int i = 0; i < 100 && exec_pc != 16'd5; i++) cycle();
      ready = 1'b0;
      repeat (10) cycle();
      chk("full_head", 32'(s_ipc), 32'd5);
      chk("full_req_low", 32'(s_req), 32'd0);
      clear_logs();
      jmp = 1'b1; jmp_tgt = 16'h0100; ready = 1'b1;
      cycle();
      chk("flush_nosub", 32'(s_sub), 32'd0);
      cycle();
      chk("redir_addr", 32'(req_log[0]), 32'h0100);
      chk("bypass_ack", 32'(s_sub), 32'(BYP));
      repeat (5) cycle();
      chk("redir_first", 32'(sub_log[0]), 32'h0100);

      // redirect while a slow request is pending
      do_reset();
      ready = 1'b1; lat = 3;
      for (int i = 0; i < 200 && !(m_busy && m_addr == 16'd9); i++)
         cycle();
      chk("pc9_pending", 32'(m_busy && m_addr == 16'd9), 32'd1);
      clear_logs();
      jmp = 1'b1; jmp_tgt = 16'h0040;
      repeat (20) cycle();
      chk("disc_addr", 32'(req_log[0]), 32'h0040);
      n9 = 0;
      foreach (sub_log[k]) if (sub_log[k] == 16'd9) n9++;
      chk("disc_no9", 32'(n9), 32'd0);
      chk("disc_first", 32'(sub_log[0]), 32'h0040);

      // PC wrap
      do_reset();
      ready = 1'b1; lat = 0;
      jmp = 1'b1; jmp_tgt = 16'hFFFE;
      cycle();
      clear_logs();
      repeat (8) cycle();
      chk("wrap_a0", 32'(req_log[0]), 32'hFFFE);
      chk("wrap_a1", 32'(req_log[1]), 32'hFFFF);
      chk("wrap_a2", 32'(req_log[2]), 32'h0000);
      chk("wrap_s2", 32'(sub_log[2]), 32'h0000);

      // reset in the middle of a request
      do_reset();
      ready = 1'b1; lat = 3;
      repeat (2) cycle();
      chk("mid_req_pending", 32'(s_req), 32'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      exec_pc = '0;
      bus.i_exec_pc = '0;
      bus.i_mem_ack = 1'b1;
      bus.i_mem_data = $urandom();
      #1 chk_zero("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.i_mem_ack = 1'b0;
      m_busy = 1'b0;
      clear_logs();
      rst = 1'b1;
      repeat (6) cycle();
      chk("midrst_addr", 32'(req_log[0]), 32'd0);
      chk("midrst_sub", 32'(sub_log[0]), 32'd0);

      // random traffic with occasional branches
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom_range(3) != 0);
         lat = int'($urandom_range(3));
         if ($urandom_range(39) == 0) begin
            jmp = 1'b1;
            jmp_tgt = 16'($urandom());
            if (jmp_tgt == exec_pc) jmp_tgt = exec_pc + 16'd8;
         end
         cycle();
      end
      chk("rand_progress", 32'(sub_log.size() > 200), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
